// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller.
// Optional delay-slot mode is enabled by FETCH_CTRL_DELAY_SLOT_EN.
package fetch_ctrl_pkg;

    typedef enum logic {
        SEQ   = 1'b0,
        DSLOT = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam int          IM_WORDS_DEF = 4096;

    localparam int ADDR_W = 32;
    // One extra bit so base + size cannot wrap at the top of the map.
    localparam int CHK_W  = ADDR_W + 1;

    function automatic logic [CHK_W-1:0] im_limit(
        input logic [ADDR_W-1:0] base,
        input int                words
    );
        return {1'b0, base} + (CHK_W'(words) << 2);
    endfunction

endpackage

// File: rtl/fetch_addr_chk.sv
// Alignment and instruction-memory range check for one address.
// Used for both the current pc and the winning redirect target.
module fetch_addr_chk
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE  = RESET_PC_DEF,
    parameter int                WORDS = IM_WORDS_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              ok
);

    logic [CHK_W-1:0] ext;
    logic [CHK_W-1:0] lim;
    logic             aligned;
    logic             in_range;

    assign ext      = {1'b0, addr};
    assign lim      = im_limit(BASE, WORDS);
    assign aligned  = (addr[1:0] == 2'b00);
    assign in_range = (addr >= BASE) && (ext < lim);
    assign ok       = aligned && in_range;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer with exception, jump and branch redirects.
// Define FETCH_CTRL_DELAY_SLOT_EN for one-instruction delay-slot redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    input  logic        br_req,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        addr_err
);

    state_t      state;
    state_t      state_n;
    logic [31:0] pend;
    logic [31:0] pend_n;
    logic        err_n;
    logic        red_req;
    logic [31:0] red_tgt;
    logic        tgt_ok;
    logic [31:0] pc_inc;

    fetch_addr_chk #(
        .BASE  (RESET_PC),
        .WORDS (IM_WORDS)
    ) u_pc_chk (
        .addr (pc),
        .ok   (fetch_valid)
    );

    fetch_addr_chk #(
        .BASE  (RESET_PC),
        .WORDS (IM_WORDS)
    ) u_tgt_chk (
        .addr (red_tgt),
        .ok   (tgt_ok)
    );

    assign pc_inc = pc + 32'd4;

    // Only the highest-priority control-transfer request is considered.
    always_comb begin
        red_req = 1'b0;
        red_tgt = '0;
        if (jr_req) begin
            red_req = 1'b1;
            red_tgt = jr_target;
        end else if (jmp_req) begin
            red_req = 1'b1;
            red_tgt = jmp_target;
        end else if (br_req) begin
            red_req = 1'b1;
            red_tgt = br_target;
        end
    end

    always_comb begin
        npc     = pc_inc;
        state_n = state;
        pend_n  = pend;
        err_n   = addr_err;
        flush   = 1'b0;
        if (exc_req) begin
            npc     = EXC_VEC;
            flush   = 1'b1;
            state_n = SEQ;
            pend_n  = '0;
        end else if (stall) begin
            npc = pc;
        end else if (state == DSLOT) begin
            // Redirects arriving in the delay slot are dropped.
            npc     = pend;
            state_n = SEQ;
            pend_n  = '0;
        end else if (red_req && !tgt_ok) begin
            npc   = EXC_VEC;
            flush = 1'b1;
            err_n = 1'b1;
        end else if (red_req) begin
`ifdef FETCH_CTRL_DELAY_SLOT_EN
            pend_n  = red_tgt;
            state_n = DSLOT;
`else
            npc   = red_tgt;
            flush = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            state    <= SEQ;
            pend     <= '0;
            addr_err <= 1'b0;
        end else begin
            pc       <= npc;
            state    <= state_n;
            pend     <= pend_n;
            addr_err <= err_n;
        end
    end

endmodule
